// File: rtl/btn_debounce_pkg.sv
// Shared constants and helpers for the push-button / GPIO debouncer.
// Default debounce window is 10 ms at the 50 MHz board clock.
package btn_debounce_pkg;

    localparam int CLK_HZ                  = 32'd50_000_000;
    localparam int DEBOUNCE_MS_DEFAULT     = 32'd10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 32'd1000 * DEBOUNCE_MS_DEFAULT;

    // Bits needed to hold a stability count of 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 32'd1);
    endfunction

endpackage : btn_debounce_pkg

// File: rtl/btn_debounce_if.sv
// Bundles the raw button inputs and the conditioned outputs of btn_debounce.
// master = the side that supplies raw inputs and consumes the clean outputs.
interface btn_debounce_if #(
    parameter int NUM_CH = 9
) ();

    logic [NUM_CH-1:0] btn_raw;
    logic [NUM_CH-1:0] btn_level;
    logic [NUM_CH-1:0] btn_rise;
    logic [NUM_CH-1:0] btn_fall;
    logic [NUM_CH-1:0] btn_toggle;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  btn_toggle
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output btn_toggle
    );

endinterface : btn_debounce_if

// File: rtl/btn_debounce_chan.sv
// One debounce channel: synchroniser chain, saturating stability counter,
// registered level, one-cycle rise/fall pulses and an optional toggle latch.
// Toggle latch is built only when BTN_DEBOUNCE_TOGGLE_EN is defined.
module btn_debounce_chan
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Shift the raw input into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    // Stability counter: any sample equal to the current level restarts the window.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_s == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == LAST) begin
            level_d = sync_s;
            cnt_d   = {CW{1'b0}};
            rise_d  = sync_s;
            fall_d  = ~sync_s;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef BTN_DEBOUNCE_TOGGLE_EN
    logic toggle_q, toggle_d;

    // Flip the latch in the same cycle the rise pulse is registered.
    always_comb begin
        if (rise_d) begin
            toggle_d = ~toggle_q;
        end else begin
            toggle_d = toggle_q;
        end
    end

    // Toggle latch register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign toggle_o = toggle_q;
`else
    assign toggle_o = 1'b0;
`endif

endmodule : btn_debounce_chan

// File: rtl/btn_debounce.sv
// Multi-channel push-button / GPIO debouncer for the DE2-115 board.
// Each channel is an independent btn_debounce_chan instance.
// Optional toggle outputs: define BTN_DEBOUNCE_TOGGLE_EN.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NUM_CH          = 9,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic         clock_50,
    input  logic         reset_n,
    btn_debounce_if.slave bus
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_debounce: SYNC_STAGES must be >= 2");
    end

    logic [NUM_CH-1:0] level_s;
    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] fall_s;
    logic [NUM_CH-1:0] toggle_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk      (clock_50),
            .rst_n    (reset_n),
            .raw_i    (bus.btn_raw[i]),
            .level_o  (level_s[i]),
            .rise_o   (rise_s[i]),
            .fall_o   (fall_s[i]),
            .toggle_o (toggle_s[i])
        );
    end

    assign bus.btn_level  = level_s;
    assign bus.btn_rise   = rise_s;
    assign bus.btn_fall   = fall_s;
    assign bus.btn_toggle = toggle_s;

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: a DEBOUNCE_CYCLES=4 instance and a
// DEBOUNCE_CYCLES=1 instance share stimulus and are compared every cycle
// against a window-based reference model, plus directed timing checks.
module tb_btn_debounce;

    localparam int NCH = 9;
    localparam int DC  = 4;
`ifdef BTN_DEBOUNCE_TOGGLE_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] raw_s;
    int             tests_run    = 0;
    int             tests_failed = 0;

    btn_debounce_if #(.NUM_CH(NCH)) bus4 ();
    btn_debounce_if #(.NUM_CH(NCH)) bus1 ();
    assign bus4.btn_raw = raw_s;
    assign bus1.btn_raw = raw_s;

    btn_debounce #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(2)) dut4 (
        .clock_50 (clk), .reset_n (rst_n), .bus (bus4));
    btn_debounce #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) dut1 (
        .clock_50 (clk), .reset_n (rst_n), .bus (bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // reference model state
    logic [NCH-1:0] dl[$];
    logic [NCH-1:0] hist[$];
    int             since[NCH];
    logic [NCH-1:0] e_lvl, e_rise, e_fall, e_tog;
    logic [NCH-1:0] d1[$];
    logic [NCH-1:0] e1_lvl, e1_rise, e1_fall, e1_tog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dl   = '{9'h000, 9'h000};
        d1   = '{9'h000, 9'h000};
        hist.delete();
        for (int c = 0; c < NCH; c++) since[c] = 0;
        e_lvl = '0; e_rise = '0; e_fall = '0; e_tog = '0;
        e1_lvl = '0; e1_rise = '0; e1_fall = '0; e1_tog = '0;
    endtask

    task automatic check_all();
        chk("lvl4",  32'(bus4.btn_level),  32'(e_lvl));
        chk("rise4", 32'(bus4.btn_rise),   32'(e_rise));
        chk("fall4", 32'(bus4.btn_fall),   32'(e_fall));
        chk("tog4",  32'(bus4.btn_toggle), 32'(e_tog));
        chk("lvl1",  32'(bus1.btn_level),  32'(e1_lvl));
        chk("rise1", 32'(bus1.btn_rise),   32'(e1_rise));
        chk("fall1", 32'(bus1.btn_fall),   32'(e1_fall));
        chk("tog1",  32'(bus1.btn_toggle), 32'(e1_tog));
    endtask

    // One clock edge: advance the model, then compare both DUTs 1 time unit later.
    task automatic tick();
        logic [NCH-1:0] seen, nl1;
        bit             all_diff;
        @(posedge clk);
        seen = dl.pop_front();
        dl.push_back(raw_s);
        hist.push_back(seen);
        if (hist.size() > DC) void'(hist.pop_front());
        e_rise = '0;
        e_fall = '0;
        for (int c = 0; c < NCH; c++) begin
            if (since[c] < DC) since[c]++;
            if (since[c] >= DC) begin
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (hist[hist.size()-1-k][c] == e_lvl[c]) all_diff = 1'b0;
                if (all_diff) begin
                    e_lvl[c] = ~e_lvl[c];
                    since[c] = 0;
                    if (e_lvl[c]) begin
                        e_rise[c] = 1'b1;
                        if (TOG_EN) e_tog[c] = ~e_tog[c];
                    end else begin
                        e_fall[c] = 1'b1;
                    end
                end
            end
        end
        nl1     = d1.pop_front();
        d1.push_back(raw_s);
        e1_rise = nl1 & ~e1_lvl;
        e1_fall = ~nl1 & e1_lvl;
        if (TOG_EN) e1_tog = e1_tog ^ e1_rise;
        e1_lvl  = nl1;
        #1;
        check_all();
    endtask

    initial begin
        int n4, n1, cnt;
        logic [NCH-1:0] acc;
        logic [NCH-1:0] pat;
        logic [NCH-1:0] tgt;
        logic [2:0] tog_seen;

        // 1. reset with all inputs held high
        rst_n = 1'b0;
        raw_s = 9'h1FF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("rst_level", 32'(bus4.btn_level), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        chk("rel_lvl_e5", 32'(bus4.btn_level), 32'h0);
        tick();
        chk("rel_lvl_e6",  32'(bus4.btn_level), 32'h1FF);
        chk("rel_rise_e6", 32'(bus4.btn_rise),  32'h1FF);
        tick();
        chk("rel_rise_e7", 32'(bus4.btn_rise),  32'h0);

        // settle everything low
        raw_s = 9'h000;
        repeat (10) tick();

        // 2. clean press / release on ch0
        raw_s[0] = 1'b1;
        n4 = 0; n1 = 0; acc = '0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (n4 == 0 && bus4.btn_level[0]) n4 = i;
            if (n1 == 0 && bus1.btn_level[0]) n1 = i;
            acc = acc | bus4.btn_level | bus4.btn_rise;
        end
        chk("ch0_rise_lat4", 32'(n4), 32'd6);
        chk("ch0_rise_lat1", 32'(n1), 32'd3);
        chk("ch0_others",    32'(acc), 32'h001);
        raw_s[0] = 1'b0;
        n4 = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (n4 == 0 && bus4.btn_fall[0]) n4 = i;
        end
        chk("ch0_fall_lat4", 32'(n4), 32'd6);

        // 3. bounce rejection on ch3
        pat = 9'b011110111;   // applied LSB first: 1,1,1,0,1,1,1,1
        n4 = 0; cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            raw_s[3] = (i <= 8) ? pat[i-1] : 1'b1;
            tick();
            if (n4 == 0 && bus4.btn_level[3]) n4 = i;
            if (bus4.btn_rise[3]) cnt++;
        end
        chk("ch3_bounce_lat",   32'(n4),  32'd10);
        chk("ch3_bounce_rises", 32'(cnt), 32'd1);
        raw_s[3] = 1'b0;
        repeat (10) tick();

        // 4. short pulse on ch5 is rejected
        acc = '0;
        raw_s[5] = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            if (i == 4) raw_s[5] = 1'b0;
            tick();
            acc[0] = acc[0] | bus4.btn_level[5] | bus4.btn_rise[5] | bus4.btn_fall[5];
        end
        chk("ch5_short", 32'(acc[0]), 32'h0);

        // 5. reset while ch2 is mid-count (cnt = 2)
        raw_s[2] = 1'b1;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        raw_s[2] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            acc[0] = acc[0] | bus4.btn_level[2] | bus4.btn_rise[2] | bus4.btn_fall[2];
        end
        chk("ch2_midreset", 32'(acc[0]), 32'h0);

        // 6. three clean presses on ch8
        for (int p = 0; p < 3; p++) begin
            raw_s[8] = 1'b1;
            repeat (10) tick();
            tog_seen[p] = bus4.btn_toggle[8];
            raw_s[8] = 1'b0;
            repeat (10) tick();
        end
        chk("ch8_toggle_seq", 32'(tog_seen), TOG_EN ? 32'h5 : 32'h0);

        // 7. randomized bouncy traffic on all channels
        tgt = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 15) == 0) tgt[c] = ~tgt[c];
                raw_s[c] = ($urandom_range(0, 7) == 0) ? ~tgt[c] : tgt[c];
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_btn_debounce
